// File: rtl/addsub_seq.sv
// Multi-cycle ADD/SUB/SLT/SLTU unit that adds CHUNK bits per clock, with the carry between chunks held in a register.
// Latency: WIDTH/CHUNK cycles from the accept edge to out_valid. One operation is in flight at a time.
// Backpressure: in_ready is high only in IDLE. The result and flags stay stable while out_valid=1 and out_ready=0.
//
// Ports:
//   clk, reset           single clock; synchronous active-high reset
//   in_valid/in_ready    operand handshake; in_valid is ignored while the unit is busy
//   A, B [WIDTH]         operands
//   op [2]               00 ADD, 01 SUB, 11 SLT (signed), 10 SLTU or signed saturating ADD
//   out_valid/out_ready  result handshake
//   out [WIDTH]          result
//   Zero                 set when out is zero
//   Overflow             signed overflow of the underlying A+B or A-B
//   Cout                 carry out of the top bit
//
// Build option ADDSUB_SEQ_SAT_EN:
//   defined   - op=10 is a signed saturating ADD
//   undefined - op=10 is SLTU
module addsub_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             Zero,
  output logic             Overflow,
  output logic             Cout
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCH - 1);

  generate
    if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_param
      $error("addsub_seq: WIDTH must be >= 2 and a multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_sum, r_out;
  logic [1:0]       r_op;
  logic [CW-1:0]    r_cnt;
  logic             r_carry, r_zero, r_ovf, r_cout;

  // Decide whether the op subtracts. With saturation enabled, op=10 is an add.
  function automatic logic f_sub(input logic [1:0] o);
`ifdef ADDSUB_SEQ_SAT_EN
    return (o == 2'b01) || (o == 2'b11);
`else
    return (o != 2'b00);
`endif
  endfunction

  logic             w_sub;
  int               w_base;
  logic [CHUNK-1:0] w_a_c, w_b_c, w_c_sum;
  logic             w_c_cout;
  logic [WIDTH-1:0] w_s, w_res;
  logic             w_s_msb, w_bx_msb, w_ovf;

  // Chunk adder. Subtraction is A + ~B + 1, where the +1 is the initial carry.
  always_comb begin
    w_sub  = f_sub(r_op);
    w_base = int'(r_cnt) * CHUNK;
    w_a_c  = r_a[w_base +: CHUNK];
    w_b_c  = r_b[w_base +: CHUNK] ^ {CHUNK{w_sub}};
    {w_c_cout, w_c_sum} = {1'b0, w_a_c} + {1'b0, w_b_c} + {{CHUNK{1'b0}}, r_carry};
  end

  // The final chunk is always the top one, so the full sum is the stored
  // lower chunks plus this cycle's chunk. It is only meaningful when r_cnt == LAST.
  always_comb begin
    w_s                    = r_sum;
    w_s[WIDTH-1 -: CHUNK]  = w_c_sum;
    w_s_msb                = w_c_sum[CHUNK-1];
    w_bx_msb               = r_b[WIDTH-1] ^ w_sub;
    w_ovf                  = (r_a[WIDTH-1] ^ w_s_msb) & ~(r_a[WIDTH-1] ^ w_bx_msb);
    w_res                  = w_s;
    case (r_op)
      2'b11: begin
        // Signed less-than: the sign of A-B, corrected by overflow.
        w_res    = '0;
        w_res[0] = w_s_msb ^ w_ovf;
      end
      2'b10: begin
`ifdef ADDSUB_SEQ_SAT_EN
        // Overflow on an add means A and B share a sign, so clamp toward A's sign.
        if (w_ovf) w_res = {r_a[WIDTH-1], {(WIDTH-1){~r_a[WIDTH-1]}}};
`else
        // Unsigned less-than: A-B borrows exactly when there is no carry out.
        w_res    = '0;
        w_res[0] = ~w_c_cout;
`endif
      end
      default: w_res = w_s;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // FSM next state and handshake outputs.
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = S_RUN;
      end
      S_RUN: begin
        if (r_cnt == LAST) w_next = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_out   <= '0;
      r_zero  <= 1'b0;
      r_ovf   <= 1'b0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= A;
            r_b     <= B;
            r_op    <= op;
            r_cnt   <= '0;
            r_carry <= f_sub(op);
          end
        end
        S_RUN: begin
          r_sum[w_base +: CHUNK] <= w_c_sum;
          r_carry                <= w_c_cout;
          if (r_cnt == LAST) begin
            r_out  <= w_res;
            r_zero <= (w_res == '0);
            r_ovf  <= w_ovf;
            r_cout <= w_c_cout;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign out      = r_out;
  assign Zero     = r_zero;
  assign Overflow = r_ovf;
  assign Cout     = r_cout;

endmodule

// File: tb/tb_addsub_seq.sv
// Bench for addsub_seq: directed cases plus random operations, checked against an arithmetic reference model.
// Also exercises a single-chunk instance (CHUNK == WIDTH).
module tb_addsub_seq;

  localparam int W   = 32;
  localparam int C   = 8;
  localparam int NCH = W / C;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]  A, B, out;
  logic [1:0]    op;
  logic          Zero, Overflow, Cout;

  logic          d1_in_valid, d1_in_ready, d1_out_valid, d1_out_ready;
  logic [W-1:0]  d1_A, d1_B, d1_out;
  logic [1:0]    d1_op;
  logic          d1_Zero, d1_Overflow, d1_Cout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  addsub_seq #(.WIDTH(W), .CHUNK(C)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .Zero(Zero), .Overflow(Overflow), .Cout(Cout)
  );

  addsub_seq #(.WIDTH(W), .CHUNK(W)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(d1_in_valid), .in_ready(d1_in_ready),
    .A(d1_A), .B(d1_B), .op(d1_op), .out_valid(d1_out_valid), .out_ready(d1_out_ready),
    .out(d1_out), .Zero(d1_Zero), .Overflow(d1_Overflow), .Cout(d1_Cout)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference model built from plain signed and unsigned arithmetic.
  task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic z, output logic v, output logic c);
    longint sa, sb, ua, ub, sres;
    logic   is_add;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    is_add = (o == 2'b00);
`ifdef ADDSUB_SEQ_SAT_EN
    if (o == 2'b10) is_add = 1'b1;
`endif
    if (is_add) begin
      sres = sa + sb;
      c    = (ua + ub) > 64'sd4294967295;
    end else begin
      sres = sa - sb;
      c    = (ua >= ub);
    end
    v = (sres > SMAX) || (sres < SMIN);
    case (o)
      2'b11:   r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
`ifdef ADDSUB_SEQ_SAT_EN
      2'b10:   r = v ? ((sres < 0) ? 32'h80000000 : 32'h7FFFFFFF) : sres[31:0];
`else
      2'b10:   r = (a < b) ? 32'd1 : 32'd0;
`endif
      default: r = sres[31:0];
    endcase
    z = (r == 32'd0);
  endtask

  // One operation on the main DUT.
  //   hold  - cycles of out_ready=0 in DONE, with in_valid driven during them
  //   early - out_ready held high from the start
  //   junk  - in_valid driven with other operands while the unit is busy
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int hold, input bit early, input bit junk);
    logic [31:0] er;
    logic        ez, ev, ec;
    int          n;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    chk({tag, ".ready"}, 32'(in_ready), 32'd1);
    model(o, a, b, er, ez, ev, ec);
    in_valid = 1'b1; A = a; B = b; op = o; out_ready = early;
    @(posedge clk);
    @(negedge clk);
    in_valid = junk; A = ~a; B = a; op = ~o;
    chk({tag, ".busy"}, 32'(in_ready), 32'd0);
    n = 0;
    while (!out_valid && n < 50) begin @(posedge clk); n++; @(negedge clk); end
    in_valid = 1'b0;
    chk({tag, ".lat"}, 32'(n), 32'(NCH));
    chk({tag, ".out"}, out, er);
    chk({tag, ".Z"}, 32'(Zero), 32'(ez));
    chk({tag, ".V"}, 32'(Overflow), 32'(ev));
    chk({tag, ".C"}, 32'(Cout), 32'(ec));
    if (!early) begin
      for (int i = 0; i < hold; i++) begin
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk({tag, ".hold_out"}, out, er);
        chk({tag, ".hold_vld"}, 32'(out_valid), 32'd1);
        chk({tag, ".hold_rdy"}, 32'(in_ready), 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, ".pulse"}, 32'(out_valid), 32'd0);
    chk({tag, ".idle"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] er;
    logic        ez, ev, ec;
    int          n;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; op = '0;
    d1_in_valid = 1'b0; d1_out_ready = 1'b1; d1_A = '0; d1_B = '0; d1_op = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out", out, 32'd0);
    chk("rst.flags", {29'd0, Zero, Overflow, Cout}, 32'd0);

    run_op("add5_3",   2'b00, 32'h5,        32'h3,        0, 1'b0, 1'b0);
    run_op("sub_min1", 2'b01, 32'h80000000, 32'h1,        0, 1'b0, 1'b0);
    run_op("slt_ovf",  2'b11, 32'h80000000, 32'h7FFFFFFF, 0, 1'b0, 1'b0);
    run_op("slt_eq",   2'b11, 32'h5,        32'h5,        0, 1'b0, 1'b0);
    run_op("add_wrap", 2'b00, 32'hFFFFFFFF, 32'h1,        0, 1'b0, 1'b0);
    run_op("op10",     2'b10, 32'h1,        32'hFFFFFFFF, 0, 1'b0, 1'b0);
    run_op("stall3",   2'b00, 32'h12345678, 32'h11111111, 3, 1'b0, 1'b1);
    run_op("rdy_high", 2'b01, 32'h3,        32'h9,        0, 1'b1, 1'b0);
`ifdef ADDSUB_SEQ_SAT_EN
    run_op("sadd_pos", 2'b10, 32'h7FFFFFFF, 32'h1,        0, 1'b0, 1'b0);
    run_op("sadd_neg", 2'b10, 32'h80000000, 32'hFFFFFFFF, 0, 1'b0, 1'b0);
`endif

    // Reset during the second RUN cycle discards the operation.
    @(negedge clk);
    in_valid = 1'b1; A = 32'hAAAA5555; B = 32'h1; op = 2'b00;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rstrun.out_valid", 32'(out_valid), 32'd0);
    chk("rstrun.in_ready", 32'(in_ready), 32'd1);
    chk("rstrun.out", out, 32'd0);
    repeat (6) @(negedge clk);
    chk("rstrun.quiet", 32'(out_valid), 32'd0);

    for (int i = 0; i < 40; i++) begin
      run_op("rand", 2'($urandom_range(0, 3)), $urandom, (i % 4 == 0) ? $urandom_range(0, 3) : $urandom,
             $urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Single-chunk instance: one RUN cycle.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      d1_in_valid = 1'b1; d1_A = $urandom; d1_B = $urandom; d1_op = 2'($urandom_range(0, 3));
      if (i == 0) begin d1_A = 32'h7FFFFFFF; d1_B = 32'h1; end
      model(d1_op, d1_A, d1_B, er, ez, ev, ec);
      @(posedge clk);
      @(negedge clk);
      d1_in_valid = 1'b0;
      n = 0;
      while (!d1_out_valid && n < 20) begin @(posedge clk); n++; @(negedge clk); end
      chk("d1.lat", 32'(n), 32'd1);
      chk("d1.out", d1_out, er);
      chk("d1.flags", {29'd0, d1_Zero, d1_Overflow, d1_Cout}, {29'd0, ez, ev, ec});
      @(posedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
